fifo_pop_stage: RTL and testbench

Registered consumer stage that sits directly downstream of the generic FIFO's pop side. It converts the FIFO's combinational empty/pop/data_pop interface into a registered valid/ready stream for the next pipeline stage (decode/issue). A 2-entry buffer (main + skid) sustains one transfer per cycle. There is no combinational path from out_ready to fifo_pop.

---
 rtl/fifo_pop_stage_if.sv | 24 ++
 rtl/fifo_pop_stage.sv | 79 +++++++
 tb/tb_fifo_pop_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pop_stage_if.sv
// Pop-side bundle between the upstream FIFO, this stage and the downstream consumer.
interface fifo_pop_stage_if #(
  parameter int unsigned DW = 64
) ();
  logic          fifo_empty;
  logic [DW-1:0] data_pop;
  logic          fifo_pop;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    occupancy;

  // Environment side: owns the FIFO head and the downstream ready.
  modport master (
    output fifo_empty, data_pop, out_ready,
    input  fifo_pop, out_valid, out_data, occupancy
  );

  // Stage side.
  modport slave (
    input  fifo_empty, data_pop, out_ready,
    output fifo_pop, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/fifo_pop_stage.sv
// Registered consumer stage for a FIFO pop port: converts empty/pop/data_pop into a
// registered valid/ready stream using a main entry plus a skid entry. The pop request
// depends only on local state, never on out_ready.
module fifo_pop_stage #(
  parameter int unsigned DW = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       flush,
  fifo_pop_stage_if.slave bus
);

  logic          main_valid_q, main_valid_d;
  logic [DW-1:0] main_data_q, main_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          pop;
  logic          out_valid;
  logic          take;

  // Pop whenever a free slot is guaranteed: skid empty means at least one slot is free.
  always_comb begin
    pop       = ~RST & ~flush & ~bus.fifo_empty & ~skid_valid_q;
    out_valid = main_valid_q & ~flush;
    take      = out_valid & bus.out_ready;
  end

  // Drive the downstream stream and the occupancy count.
  always_comb begin
    bus.fifo_pop  = pop;
    bus.out_valid = out_valid;
    bus.out_data  = main_data_q;
    bus.occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  end

  // Next-state for main and skid entries.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      // Drop buffered entries; data registers keep their stale contents.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!pop) begin
      if (take) begin
        main_valid_d = skid_valid_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q) begin
      main_valid_d = 1'b1;
      main_data_d  = bus.data_pop;
    end else if (take) begin
      // Skid is empty here since pop implies ~skid_valid_q.
      main_data_d  = bus.data_pop;
    end else begin
      skid_valid_d = 1'b1;
      skid_data_d  = bus.data_pop;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_fifo_pop_stage.sv
// Testbench for fifo_pop_stage: directed scenarios plus a randomized soak, with an
// upstream FIFO model feeding an expected-data queue and a monitor checking transfers.
module tb_fifo_pop_stage;
  localparam int unsigned DW = 64;

  logic CLK;
  logic RST;
  logic flush;

  fifo_pop_stage_if #(.DW(DW)) bus ();

  fifo_pop_stage #(.DW(DW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .flush (flush),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [DW-1:0] up_q[$];   // upstream FIFO contents
  logic [DW-1:0] exp_q[$];  // entries popped into the stage, not yet transferred
  logic          hold_empty;
  logic          pop_pend;
  logic [DW-1:0] pend_data;
  int            n_chk;
  int            n_fail;

  localparam logic [DW-1:0] VA = 64'hA000_0000_0000_000A;
  localparam logic [DW-1:0] VB = 64'hB000_0000_0000_000B;
  localparam logic [DW-1:0] VC = 64'hC000_0000_0000_000C;
  localparam logic [DW-1:0] VD = 64'hD000_0000_0000_000D;
  localparam logic [DW-1:0] VE = 64'hE000_0000_0000_000E;
  localparam logic [DW-1:0] VF = 64'hF000_0000_0000_000F;
  localparam logic [DW-1:0] VG = 64'h1000_0000_0000_0001;
  localparam logic [DW-1:0] VH = 64'h2000_0000_0000_0002;
  localparam logic [DW-1:0] VI = 64'h3000_0000_0000_0003;
  localparam logic [DW-1:0] VJ = 64'h4000_0000_0000_0004;
  localparam logic [DW-1:0] VK = 64'h5000_0000_0000_0005;
  localparam logic [DW-1:0] VL = 64'h6000_0000_0000_0006;
  localparam logic [DW-1:0] VM = 64'h7000_0000_0000_0007;
  localparam logic [DW-1:0] VN = 64'h8000_0000_0000_0008;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = hold_empty || (up_q.size() == 0);
    bus.data_pop   = (up_q.size() != 0) ? up_q[0] : '0;
  endtask

  // One clock: retire the pop seen last cycle, then apply the new inputs.
  task automatic cyc(input logic rst, input logic fl, input logic rdy, input logic hold);
    @(posedge CLK);
    #1;
    if (pop_pend) begin
      exp_q.push_back(pend_data);
      if (up_q.size() != 0) void'(up_q.pop_front());
    end
    RST           = rst;
    flush         = fl;
    bus.out_ready = rdy;
    hold_empty    = hold;
    refresh();
    #1;
  endtask

  // Upstream FIFO: latch what the stage pops this cycle.
  always @(negedge CLK) begin
    pop_pend  = bus.fifo_pop;
    pend_data = bus.data_pop;
    if (bus.fifo_empty) check("pop_on_empty", {63'd0, bus.fifo_pop}, '0);
  end

  // Monitor: compare transfers against the expected queue and check invariants.
  always @(negedge CLK) begin
    check("occupancy", {62'd0, bus.occupancy}, DW'(exp_q.size()));
    if (dut.skid_valid_q) check("skid_implies_main", {63'd0, dut.main_valid_q}, 64'd1);
    if (flush) check("flush_masks_valid", {63'd0, bus.out_valid}, '0);
    if (RST || flush) begin
      exp_q.delete();
    end else if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_transfer", bus.out_data, '0);
        n_fail += (bus.out_data === '0) ? 1 : 0;
      end else begin
        check("out_data_order", bus.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    pop_pend = 1'b0;
    pend_data = '0;
    hold_empty = 1'b0;
    RST = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;

    // Reset then stream A,B,C.
    up_q.push_back(VA); up_q.push_back(VB); up_q.push_back(VC);
    refresh();
    cyc(1, 0, 1, 0);
    check("rst_no_pop", {63'd0, bus.fifo_pop}, '0);
    cyc(1, 0, 1, 0);
    check("rst_out_valid", {63'd0, bus.out_valid}, '0);
    check("rst_out_data", bus.out_data, '0);
    cyc(0, 0, 1, 0);
    check("s1_c0_pop", {63'd0, bus.fifo_pop}, 64'd1);
    check("s1_c0_occ", {62'd0, bus.occupancy}, 64'd0);
    cyc(0, 0, 1, 0);
    check("s1_c1_valid", {63'd0, bus.out_valid}, 64'd1);
    check("s1_c1_data", bus.out_data, VA);
    check("s1_c1_pop", {63'd0, bus.fifo_pop}, 64'd1);
    cyc(0, 0, 1, 0);
    check("s1_c2_data", bus.out_data, VB);
    cyc(0, 0, 1, 0);
    check("s1_c3_data", bus.out_data, VC);
    check("s1_c3_pop", {63'd0, bus.fifo_pop}, '0);
    cyc(0, 0, 1, 0);
    check("s1_c4_occ", {62'd0, bus.occupancy}, 64'd0);

    // Backpressure with D,E,F,G.
    up_q.push_back(VD); up_q.push_back(VE); up_q.push_back(VF); up_q.push_back(VG);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("s2_c1_pop", {63'd0, bus.fifo_pop}, 64'd1);
    cyc(0, 0, 0, 0);
    check("s2_c2_occ", {62'd0, bus.occupancy}, 64'd2);
    check("s2_c2_pop", {63'd0, bus.fifo_pop}, '0);
    cyc(0, 0, 0, 0);
    check("s2_c3_hold", bus.out_data, VD);
    cyc(0, 0, 1, 0);
    check("s2_c4_pop", {63'd0, bus.fifo_pop}, '0);
    cyc(0, 0, 1, 0);
    check("s2_c5_data", bus.out_data, VE);
    check("s2_c5_pop", {63'd0, bus.fifo_pop}, 64'd1);
    cyc(0, 0, 1, 0);
    check("s2_c6_data", bus.out_data, VF);
    cyc(0, 0, 1, 0);
    check("s2_c7_data", bus.out_data, VG);
    cyc(0, 0, 1, 0);

    // Flush with full buffer (H,I), N waiting upstream.
    up_q.push_back(VH); up_q.push_back(VI);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("s3_full", {62'd0, bus.occupancy}, 64'd2);
    up_q.push_back(VN);
    cyc(0, 1, 1, 0);
    check("s3_flush_valid", {63'd0, bus.out_valid}, '0);
    check("s3_flush_pop", {63'd0, bus.fifo_pop}, '0);
    cyc(0, 0, 1, 0);
    check("s3_after_occ", {62'd0, bus.occupancy}, 64'd0);
    check("s3_after_pop", {63'd0, bus.fifo_pop}, 64'd1);
    cyc(0, 0, 1, 0);
    check("s3_refill", bus.out_data, VN);
    cyc(0, 0, 1, 0);

    // Simultaneous pop and take with main full, skid empty.
    up_q.push_back(VJ);
    cyc(0, 0, 0, 0);
    up_q.push_back(VK);
    cyc(0, 0, 1, 0);
    check("s4_main_j", bus.out_data, VJ);
    check("s4_pop", {63'd0, bus.fifo_pop}, 64'd1);
    cyc(0, 0, 1, 0);
    check("s4_main_k", bus.out_data, VK);
    check("s4_occ", {62'd0, bus.occupancy}, 64'd1);
    cyc(0, 0, 1, 0);

    // Reset mid-transfer with a full buffer.
    up_q.push_back(VL); up_q.push_back(VM);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    check("s5_rst_pop", {63'd0, bus.fifo_pop}, '0);
    cyc(0, 0, 1, 0);
    check("s5_valid", {63'd0, bus.out_valid}, '0);
    check("s5_occ", {62'd0, bus.occupancy}, 64'd0);
    check("s5_data", bus.out_data, '0);

    // Random out_ready and upstream emptiness.
    for (int i = 0; i < 10000; i++) begin
      if (up_q.size() < 8 && $urandom_range(1, 0) == 1) up_q.push_back({$urandom, $urandom});
      cyc(0, 0, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
    end
    for (int i = 0; i < 200; i++) begin
      if (up_q.size() == 0 && exp_q.size() == 0 && bus.occupancy == 2'd0 && !pop_pend) break;
      cyc(0, 0, 1, 0);
    end
    check("drain_exp", DW'(exp_q.size()), '0);
    check("drain_up", DW'(up_q.size()), '0);

    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
